// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types and defaults for the synth verification blocks
// Contents: fm_state_e (IDLE, ARM, MEASURE), FM_WIDTH, FM_MIN_PERIOD.
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } fm_state_e;

  localparam int unsigned FM_WIDTH      = 16;
  localparam int unsigned FM_MIN_PERIOD = 2;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - 2-flop synchronizer with registered rising-edge pulse
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   async_i  in   asynchronous level input
//   pulse_o  out  one-cycle pulse, 3 cycles after a 0->1 on async_i
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic pulse_o
);

  logic [1:0] sync_q;
  logic       hist_q;
  logic       pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b00;
      hist_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], async_i};
      hist_q  <= sync_q[1];
      pulse_q <= sync_q[1] & ~hist_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - measures tone period in clk cycles with lock and timeout
// Optional: FREQ_METER_AVG_EN reports the average of every 4 accepted periods.
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   en            in   measurement enable; low forces IDLE
//   tone_in       in   asynchronous tone under test
//   period        out  last reported period (WIDTH bits)
//   period_valid  out  one-cycle pulse when period updates
//   locked        out  period stable for LOCK_COUNT consecutive measurements
//   timeout       out  one-cycle pulse when the counter saturates without an edge
module freq_meter
  import synth_pkg::*;
#(
  parameter int unsigned WIDTH      = FM_WIDTH,
  parameter int unsigned MIN_PERIOD = FM_MIN_PERIOD,
  parameter int unsigned TOL        = 1,
  parameter int unsigned LOCK_COUNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tone_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int unsigned      LW       = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] MIN_V    = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH-1:0] TOL_V    = WIDTH'(TOL);
  localparam logic [LW-1:0]    LOCK_MAX = LW'(LOCK_COUNT);

  fm_state_e        state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [LW-1:0]    lock_q, lock_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;

  logic             tone_edge;
  logic             accept;
  logic             stable;
  logic [WIDTH-1:0] diff;

  edge_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (tone_in),
    .pulse_o (tone_edge)
  );

  assign accept = tone_edge && (cnt_q >= MIN_V);
  assign diff   = (cnt_q >= last_q) ? (cnt_q - last_q) : (last_q - cnt_q);
  // lock_q == 0 marks the first accepted period since ARM; it is never "stable".
  assign stable = (lock_q != '0) && (diff <= TOL_V);

`ifdef FREQ_METER_AVG_EN
  logic [WIDTH+1:0] sum_q, sum_d;
  logic [WIDTH+1:0] sum_n;
  logic [1:0]       nsamp_q, nsamp_d;

  assign sum_n = sum_q + {2'b00, cnt_q};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    last_d    = last_q;
    lock_d    = lock_q;
    locked_d  = locked_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
`ifdef FREQ_METER_AVG_EN
    sum_d     = sum_q;
    nsamp_d   = nsamp_q;
    // Any cycle outside MEASURE discards a partial average.
    if (state_q != MEASURE) begin
      sum_d   = '0;
      nsamp_d = 2'd0;
    end
`endif
    if (!en) begin
      state_d  = IDLE;
      cnt_d    = WIDTH'(1);
      lock_d   = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d    = WIDTH'(1);
          lock_d   = '0;
          locked_d = 1'b0;
          state_d  = ARM;
        end
        ARM: begin
          if (tone_edge) begin
            cnt_d   = WIDTH'(1);
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          // An accepted edge takes priority over saturation.
          if (accept) begin
            cnt_d    = WIDTH'(1);
            last_d   = cnt_q;
            lock_d   = stable ? ((lock_q == LOCK_MAX) ? lock_q : lock_q + LW'(1)) : LW'(1);
            locked_d = (lock_d == LOCK_MAX);
`ifdef FREQ_METER_AVG_EN
            if (nsamp_q == 2'd3) begin
              period_d = sum_n[WIDTH+1:2];
              valid_d  = 1'b1;
              sum_d    = '0;
              nsamp_d  = 2'd0;
            end else begin
              sum_d   = sum_n;
              nsamp_d = nsamp_q + 2'd1;
            end
`else
            period_d = cnt_q;
            valid_d  = 1'b1;
`endif
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            lock_d    = '0;
            state_d   = ARM;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= WIDTH'(1);
      period_q  <= '0;
      last_q    <= '0;
      lock_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
`ifdef FREQ_METER_AVG_EN
      sum_q     <= '0;
      nsamp_q   <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      last_q    <= last_d;
      lock_q    <= lock_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
`ifdef FREQ_METER_AVG_EN
      sum_q     <= sum_d;
      nsamp_q   <= nsamp_d;
`endif
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - scoreboard testbench for freq_meter
module tb_freq_meter;

  localparam int W    = 8;
  localparam int MINP = 50;
  localparam int TOL  = 1;
  localparam int LC   = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         tone_in;
  logic [W-1:0] period;
  logic         period_valid;
  logic         locked;
  logic         timeout;

  always #5 clk = ~clk;

  freq_meter #(
    .WIDTH      (W),
    .MIN_PERIOD (MINP),
    .TOL        (TOL),
    .LOCK_COUNT (LC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .tone_in      (tone_in),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  typedef struct {
    int per;
    bit lck;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   n_to  = 0;

  int last_len = 0;
  int last_rep = 0;
  int run      = 0;
  int acc      = 0;
  int nacc     = 0;
  int last_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (timeout) n_to++;
      if (period_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_report", 1, 0);
        end else begin
          e = sb.pop_front();
          check("period", int'(period), e.per);
          check("locked", int'(locked), int'(e.lck));
          check("latency", cyc - e.cyc, 4);
        end
      end
    end
  end

  task automatic push_exp(input int per);
    sb.push_back('{per, (run == LC), cyc});
    last_exp = per;
  endtask

  task automatic disarm();
    last_len = 0;
    run      = 0;
    acc      = 0;
    nacc     = 0;
  endtask

  // One tone period of len cycles starting with a rising edge; the rising
  // edge closes the previous period, whose expected report is queued here.
  task automatic tone_period(input int len, input bit glitch);
    int d;
    @(negedge clk);
    tone_in = 1'b1;
    if (last_len >= MINP) begin
      d   = (last_len > last_rep) ? last_len - last_rep : last_rep - last_len;
      run = (run != 0 && d <= TOL) ? ((run < LC) ? run + 1 : LC) : 1;
      last_rep = last_len;
`ifdef FREQ_METER_AVG_EN
      acc  += last_len;
      nacc++;
      if (nacc == 4) begin
        push_exp(acc >> 2);
        acc  = 0;
        nacc = 0;
      end
`else
      push_exp(last_len);
`endif
    end
    last_len = len;
    for (int i = 1; i < len; i++) begin
      @(negedge clk);
      if (i == len / 2) tone_in = 1'b0;
      else if (glitch && i == 40) tone_in = 1'b0;
      else if (glitch && i == 41) tone_in = 1'b1;
    end
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    tone_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_period", int'(period), 0);
    check("rst_valid", int'(period_valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_timeout", int'(timeout), 0);
    rst = 1'b0;
    en  = 1'b1;

    // No edge: ARM waits indefinitely, nothing is reported.
    repeat (300) @(negedge clk);
    check("arm_no_timeout", n_to, 0);
    check("arm_period", int'(period), 0);

    // One edge then silence: counter saturates, single timeout.
    tone_in = 1'b1;
    repeat (20) @(negedge clk);
    tone_in = 1'b0;
    repeat (280) @(negedge clk);
    check("timeout_count", n_to, 1);
    check("timeout_locked", int'(locked), 0);
    disarm();

    // Steady 100, pitch step to 150, back to 100 with a glitch period.
    repeat (6) tone_period(100, 1'b0);
    repeat (4) tone_period(150, 1'b0);
    repeat (3) tone_period(100, 1'b0);
    tone_period(100, 1'b1);
    tone_period(100, 1'b0);

    // en dropped mid-measurement.
    en = 1'b0;
    repeat (5) @(negedge clk);
    check("en_off_locked", int'(locked), 0);
    check("en_off_period_hold", int'(period), last_exp);
    repeat (55) @(negedge clk);
    disarm();
    en = 1'b1;
    repeat (10) @(negedge clk);

    // Re-armed: 100, 101, 100, 102 exercises the tolerance boundary.
    tone_period(100, 1'b0);
    tone_period(101, 1'b0);
    tone_period(100, 1'b0);
    tone_period(102, 1'b0);
    tone_period(100, 1'b0);

    // rst mid-measurement.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_period", int'(period), 0);
    check("midrst_valid", int'(period_valid), 0);
    check("midrst_locked", int'(locked), 0);
    check("midrst_timeout", int'(timeout), 0);
    rst = 1'b0;
    disarm();
    last_exp = 0;
    repeat (3) tone_period(100, 1'b0);

    repeat (20) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("timeout_total", n_to, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
